// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: plays short ROM melodies on game events and drives the
// square-wave note generator (note_div, enable_sound, amplitude) one note at a time.
module sfx_sequencer #(
  parameter int unsigned TICK_DIV  = 1_000_000,
  parameter int unsigned GAP_TICKS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ev_start,
  input  logic        ev_eat,
  input  logic        ev_die,
  input  logic [1:0]  vol,
  input  logic        mute,
  output logic [21:0] note_div,
  output logic        enable_sound,
  output logic [15:0] amplitude,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CycW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned TickW = $clog2(30 + GAP_TICKS + 1);
  localparam logic [CycW-1:0]  CycLast = CycW'(TICK_DIV - 1);
  localparam logic [TickW-1:0] GapLast = TickW'(GAP_TICKS - 1);

  typedef enum logic [1:0] {StIdle, StPlay, StGap} state_e;

  // Melody id doubles as priority: 0 none, 1 start, 2 eat, 3 die.
  function automatic logic [2:0] mel_base(input logic [1:0] mel);
    case (mel)
      2'd2:    mel_base = 3'd3;
      2'd3:    mel_base = 3'd5;
      default: mel_base = 3'd0;
    endcase
  endfunction

  function automatic logic [1:0] mel_last(input logic [1:0] mel);
    mel_last = (mel == 2'd2) ? 2'd1 : 2'd2;
  endfunction

  function automatic logic [21:0] rom_div(input logic [2:0] idx);
    case (idx)
      3'd0:    rom_div = 22'd95601;
      3'd1:    rom_div = 22'd75872;
      3'd2:    rom_div = 22'd63775;
      3'd3:    rom_div = 22'd75872;
      3'd4:    rom_div = 22'd56817;
      3'd5:    rom_div = 22'd127550;
      3'd6:    rom_div = 22'd151514;
      default: rom_div = 22'd190838;
    endcase
  endfunction

  function automatic logic [4:0] rom_dur(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1:       rom_dur = 5'd10;
      3'd2, 3'd5, 3'd6: rom_dur = 5'd15;
      3'd3:             rom_dur = 5'd5;
      3'd4:             rom_dur = 5'd8;
      default:          rom_dur = 5'd30;
    endcase
  endfunction

  state_e            state_q, state_d;
  logic [1:0]        mel_q, mel_d;
  logic [1:0]        note_q, note_d;
  logic [CycW-1:0]   cyc_q, cyc_d;
  logic [TickW-1:0]  tick_q, tick_d;
  logic [21:0]       div_q, div_d;
  logic [15:0]       amp_q, amp_d;
  logic              done_q, done_d;

  logic              tick_end;
  logic [1:0]        ev_mel;
  logic [2:0]        cur_idx;
  logic [TickW-1:0]  dur_last;
  logic              load;
  logic [1:0]        load_mel;
  logic [1:0]        load_note;
  logic [2:0]        vol_p1;

  always_comb begin
    state_d   = state_q;
    mel_d     = mel_q;
    note_d    = note_q;
    cyc_d     = cyc_q;
    tick_d    = tick_q;
    div_d     = div_q;
    amp_d     = amp_q;
    done_d    = 1'b0;
    load      = 1'b0;
    load_mel  = mel_q;
    load_note = note_q;

    tick_end = (cyc_q == CycLast);
    cur_idx  = mel_base(mel_q) + {1'b0, note_q};
    dur_last = TickW'(rom_dur(cur_idx)) - TickW'(1);
    vol_p1   = {1'b0, vol} + 3'd1;

    if (ev_die)        ev_mel = 2'd3;
    else if (ev_eat)   ev_mel = 2'd2;
    else if (ev_start) ev_mel = 2'd1;
    else               ev_mel = 2'd0;

    // mel_q is 0 when idle, so any event starts; while active only higher priority pre-empts.
    if (ev_mel > mel_q) begin
      load      = 1'b1;
      load_mel  = ev_mel;
      load_note = 2'd0;
    end else begin
      unique case (state_q)
        StPlay: begin
          cyc_d = tick_end ? '0 : cyc_q + 1'b1;
          if (tick_end) begin
            if (tick_q == dur_last) begin
              tick_d = '0;
              if (note_q == mel_last(mel_q)) begin
                state_d = StIdle;
                mel_d   = 2'd0;
                note_d  = 2'd0;
                div_d   = '0;
                amp_d   = '0;
                done_d  = 1'b1;
              end else begin
                state_d = StGap;
              end
            end else begin
              tick_d = tick_q + 1'b1;
            end
          end
        end
        StGap: begin
          cyc_d = tick_end ? '0 : cyc_q + 1'b1;
          if (tick_end) begin
            if (tick_q == GapLast) begin
              load      = 1'b1;
              load_note = note_q + 2'd1;
            end else begin
              tick_d = tick_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end

    if (load) begin
      state_d = StPlay;
      mel_d   = load_mel;
      note_d  = load_note;
      cyc_d   = '0;
      tick_d  = '0;
      div_d   = rom_div(mel_base(load_mel) + {1'b0, load_note});
      amp_d   = {2'b00, vol_p1, 11'd0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      mel_q   <= 2'd0;
      note_q  <= 2'd0;
      cyc_q   <= '0;
      tick_q  <= '0;
      div_q   <= '0;
      amp_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mel_q   <= mel_d;
      note_q  <= note_d;
      cyc_q   <= cyc_d;
      tick_q  <= tick_d;
      div_q   <= div_d;
      amp_q   <= amp_d;
      done_q  <= done_d;
    end
  end

  assign note_div     = div_q;
  assign amplitude    = amp_q;
  assign done         = done_q;
  assign busy         = (state_q != StIdle);
  assign enable_sound = (state_q == StPlay) & ~mute;

endmodule
